// File: rtl/avalon_pio_in_irq_if.sv
// rtl/avalon_pio_in_irq_if.sv - Avalon-MM register bus and level interrupt of the input PIO
interface avalon_pio_in_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/avalon_pio_in_irq.sv
// rtl/avalon_pio_in_irq.sv - Avalon-MM input PIO with sticky edge capture and masked level irq
// Optional per-bit debounce filter enabled by defining PIO_DEBOUNCE_EN.
module avalon_pio_in_irq #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   in_port,
  avalon_pio_in_irq_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || EDGE_TYPE < 0 || EDGE_TYPE > 2 ||
      DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("avalon_pio_in_irq: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CW-1:0] db_cnt;
  logic [WIDTH-1:0]         filt_q;

  // A bit only follows sync after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt <= '0;
      filt_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == filt_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          filt_q[i] <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync;
`endif

  assign rise = filt & ~prev;
  assign fall = ~filt & prev;

  always_comb begin
    case (EDGE_TYPE)
      1:       edge_det = rise;
      2:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
  end

  assign wr  = bus.chipselect & ~bus.write_n;
  assign clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  if (WIDTH < 32) begin : g_wdata_upper
    assign unused_wdata = ^bus.writedata[31:WIDTH];
  end else begin : g_wdata_full
    assign unused_wdata = 1'b0;
  end

  // A new edge overrides a same-cycle RW1C clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      bus.readdata <= '0;
    end else begin
      prev         <= filt;
      edge_capture <= (edge_capture & ~clr) | edge_det;
      if (wr && bus.address == 2'd2) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
      case (bus.address)
        2'd0:    bus.readdata <= 32'(filt);
        2'd2:    bus.readdata <= 32'(irq_mask);
        2'd3:    bus.readdata <= 32'(edge_capture);
        default: bus.readdata <= '0;
      endcase
    end
  end

  assign bus.irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// tb/tb_avalon_pio_in_irq.sv - scoreboard bench for avalon_pio_in_irq (any-edge and falling-only instances)
module tb_avalon_pio_in_irq;
  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DB = 16;
`ifdef PIO_DEBOUNCE_EN
  localparam int LAT = SS + DB + 1;
`else
  localparam int LAT = SS + 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  avalon_pio_in_irq_if bus_a ();
  avalon_pio_in_irq_if bus_b ();

  avalon_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_a),
    .bus     (bus_a.slave)
  );

  avalon_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_b),
    .bus     (bus_b.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_req = 1'b0;

  always @(posedge clk) begin
    if (rd_req) begin
      #1;
      if (exp_q.size() > 0) check(tag_q.pop_front(), bus_a.readdata, exp_q.pop_front());
      else check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_a.address    = a;
    bus_a.writedata  = d;
    bus_a.chipselect = 1'b1;
    bus_a.write_n    = 1'b0;
    @(negedge clk);
    bus_a.chipselect = 1'b0;
    bus_a.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
    bus_a.address = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_a.address = 2'd0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = 2'd3; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    in_a = 4'hA;
    in_b = 4'hF;
    reset_n = 1'b0;
    cycles(3);
    check("rst_rdata", bus_a.readdata, 32'h0);
    check("rst_irq", 32'(bus_a.irq), 32'h0);
    check("rst_rdata_b", bus_b.readdata, 32'h0);

    // Reset release and read latency of DATA.
    reset_n = 1'b1;
    cycles(LAT - 1);
    check("data_early", bus_a.readdata, 32'h0);
    cycles(1);
    check("data_lat", bus_a.readdata, 32'hA);
    bus_read(2'd1, "reserved", 32'h0);
    bus_read(2'd3, "cap_reset_rise", 32'hA);
    check("b_no_rise_at_reset", bus_b.readdata, 32'h0);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, "reserved_wr", 32'h0);

    // Rising capture, mask gating.
    in_a = 4'h0;
    cycles(LAT + 2);
    bus_write(2'd3, 32'hF);
    bus_read(2'd3, "cap_clear", 32'h0);
    in_a = 4'h5;
    cycles(LAT + 2);
    bus_read(2'd3, "cap_rise", 32'h5);
    check("irq_masked", 32'(bus_a.irq), 32'h0);
    bus_write(2'd2, 32'h4);
    check("irq_mask_on", 32'(bus_a.irq), 32'h1);
    bus_read(2'd2, "mask_rd", 32'h4);

    // RW1C.
    bus_write(2'd3, 32'h1);
    check("irq_after_clr_b0", 32'(bus_a.irq), 32'h1);
    bus_read(2'd3, "rw1c_b0", 32'h4);
    bus_write(2'd3, 32'h4);
    check("irq_after_clr_b2", 32'(bus_a.irq), 32'h0);
    bus_read(2'd3, "rw1c_b2", 32'h0);

    // Edge landing in the same cycle as a clear of that bit.
    in_a = 4'h1;
    cycles(LAT + 2);
    bus_write(2'd3, 32'hF);
    bus_read(2'd3, "pre_coll", 32'h0);
    check("pre_coll_irq", 32'(bus_a.irq), 32'h0);
    in_a = 4'h5;
    cycles(LAT - 1);
    bus_write(2'd3, 32'h4);
    check("coll_irq", 32'(bus_a.irq), 32'h1);
    bus_read(2'd3, "coll_cap", 32'h4);

    bus_write(2'd2, 32'h0);
    check("irq_mask_off", 32'(bus_a.irq), 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, "mask_upper", 32'hF);
    check("irq_remask", 32'(bus_a.irq), 32'h1);
    bus_write(2'd3, 32'hF);
    check("irq_clear", 32'(bus_a.irq), 32'h0);
    bus_read(2'd0, "data_5", 32'h5);

    // Falling-only instance: F -> 0 -> F.
    in_b = 4'h0;
    cycles(LAT - 1);
    check("b_fall_early", bus_b.readdata, 32'h0);
    cycles(2);
    check("b_fall", bus_b.readdata, 32'hF);
    check("b_irq_masked", 32'(bus_b.irq), 32'h0);
    bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0; bus_b.writedata = 32'hF;
    cycles(1);
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
    cycles(1);
    check("b_cleared", bus_b.readdata, 32'h0);
    in_b = 4'hF;
    cycles(LAT + 2);
    check("b_rise_ignored", bus_b.readdata, 32'h0);

`ifdef PIO_DEBOUNCE_EN
    in_a = 4'h0;
    cycles(LAT + 2);
    bus_write(2'd3, 32'hF);
    bus_a.address = 2'd0;
    in_a = 4'h1;
    cycles(10);
    in_a = 4'h0;
    cycles(LAT + 5);
    bus_read(2'd0, "glitch_data", 32'h0);
    bus_read(2'd3, "glitch_cap", 32'h0);
    bus_a.address = 2'd0;
    in_a = 4'h1;
    cycles(LAT - 1);
    check("deb_data_early", bus_a.readdata, 32'h0);
    cycles(1);
    check("deb_data_lat", bus_a.readdata, 32'h1);
    cycles(20 - LAT);
    in_a = 4'h0;
    bus_read(2'd3, "deb_cap", 32'h1);
`endif

    cycles(2);
    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
